// File: rtl/jesd204b_dl_rx.sv
// JESD204B data link receiver for one lane: CGS/ILAS handshake with config capture,
// then /F/ and /A/ alignment-character restoration with frame/multiframe markers.
module jesd204b_dl_rx #(
    parameter int LANE_DATA_WIDTH = 32,
    parameter int OCTETS_PER_FR   = 5,
    parameter int FRAMES_PER_MF   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         scramble_enable,
    input  logic [LANE_DATA_WIDTH-1:0]   in,
    input  logic [LANE_DATA_WIDTH/8-1:0] ctrl_in,
    output logic                         sync_request,
    output logic                         link_up,
    output logic [LANE_DATA_WIDTH-1:0]   out,
    output logic                         out_valid,
    output logic [LANE_DATA_WIDTH/8-1:0] eof_out,
    output logic [LANE_DATA_WIDTH/8-1:0] eom_out,
    output logic [111:0]                 config_out,
    output logic                         ilas_error,
    output logic [7:0]                   unexpected_k_count
);
    localparam int NUM_OCT = LANE_DATA_WIDTH / 8;
    localparam int MF_OCT  = OCTETS_PER_FR * FRAMES_PER_MF;
    localparam int PW      = $clog2(MF_OCT) + 1;
    localparam logic [PW-1:0] LAST_OCT  = PW'(MF_OCT - 1);
    localparam logic [PW-1:0] LAST_WORD = PW'(MF_OCT - NUM_OCT);
    localparam logic [PW-1:0] FR_LEN    = PW'(OCTETS_PER_FR);
    localparam logic [7:0] K_K = 8'hBC;
    localparam logic [7:0] K_R = 8'h1C;
    localparam logic [7:0] K_A = 8'h7C;
    localparam logic [7:0] K_Q = 8'h9C;
    localparam logic [7:0] K_F = 8'hFC;

    typedef enum logic [1:0] {ST_CGS, ST_CGS_WAIT, ST_ILAS, ST_DATA} state_t;

    state_t                     state, state_nxt;
    logic [2:0]                 k_cnt, k_cnt_nxt;
    logic [PW-1:0]              pos, pos_nxt;
    logic [1:0]                 mf, mf_nxt;
    logic [7:0]                 prev, prev_nxt;
    logic [111:0]               stage, stage_nxt, config_nxt;
    logic [LANE_DATA_WIDTH-1:0] out_nxt;
    logic                       out_valid_nxt, ilas_error_nxt;
    logic [NUM_OCT-1:0]         eof_nxt, eom_nxt;
    logic [7:0]                 ukc_nxt;

    logic                       is_k_word, is_r_word, ilas_ok, legal;
    logic [PW-1:0]              oct_pos [NUM_OCT];
    logic [NUM_OCT-1:0]         eof_flag, eom_flag;
    logic [7:0]                 prev_c, octet;
    logic [2:0]                 bad_cnt;
    logic [8:0]                 ukc_sum;

    // Next-state and next-output logic; pos is kept at 0 outside ILAS/DATA so the
    // /R/ word seen in CGS_WAIT is checked as octets 0..3 of multiframe 0.
    always_comb begin
        state_nxt      = state;
        k_cnt_nxt      = k_cnt;
        pos_nxt        = pos;
        mf_nxt         = mf;
        prev_nxt       = prev;
        stage_nxt      = stage;
        config_nxt     = config_out;
        out_nxt        = '0;
        out_valid_nxt  = 1'b0;
        eof_nxt        = '0;
        eom_nxt        = '0;
        ilas_error_nxt = 1'b0;
        ukc_nxt        = unexpected_k_count;
        prev_c         = prev;
        octet          = '0;
        legal          = 1'b0;
        bad_cnt        = '0;
        ukc_sum        = '0;
        ilas_ok        = 1'b1;
        eof_flag       = '0;
        eom_flag       = '0;

        is_k_word = (in == {NUM_OCT{K_K}}) && (&ctrl_in);
        is_r_word = ctrl_in[0] && (in[7:0] == K_R);

        for (int i = 0; i < NUM_OCT; i++) begin
            oct_pos[i]  = pos + PW'(i);
            eof_flag[i] = (((oct_pos[i] + PW'(1)) % FR_LEN) == '0);
            eom_flag[i] = (oct_pos[i] == LAST_OCT);
            if (oct_pos[i] == '0) begin
                if (!(ctrl_in[i] && in[8*i +: 8] == K_R)) ilas_ok = 1'b0;
            end else if (oct_pos[i] == LAST_OCT) begin
                if (!(ctrl_in[i] && in[8*i +: 8] == K_A)) ilas_ok = 1'b0;
            end else if (mf == 2'd1 && oct_pos[i] == PW'(1)) begin
                if (!(ctrl_in[i] && in[8*i +: 8] == K_Q)) ilas_ok = 1'b0;
            end else if (ctrl_in[i]) begin
                ilas_ok = 1'b0;
            end
        end

        case (state)
            ST_CGS: begin
                if (!is_k_word) begin
                    k_cnt_nxt = '0;
                end else if (k_cnt == 3'd3) begin
                    k_cnt_nxt = '0;
                    state_nxt = ST_CGS_WAIT;
                end else begin
                    k_cnt_nxt = k_cnt + 3'd1;
                end
            end
            ST_CGS_WAIT: begin
                if (is_k_word) begin
                    state_nxt = ST_CGS_WAIT;
                end else if (is_r_word && ilas_ok) begin
                    state_nxt = ST_ILAS;
                    pos_nxt   = PW'(NUM_OCT);
                    mf_nxt    = '0;
                end else begin
                    ilas_error_nxt = is_r_word;
                    state_nxt      = ST_CGS;
                end
            end
            ST_ILAS: begin
                for (int c = 0; c < 14; c++) begin
                    for (int i = 0; i < NUM_OCT; i++) begin
                        if (mf == 2'd1 && oct_pos[i] == PW'(c + 2)) stage_nxt[8*c +: 8] = in[8*i +: 8];
                    end
                end
                if (!ilas_ok) begin
                    ilas_error_nxt = 1'b1;
                    state_nxt      = ST_CGS;
                    pos_nxt        = '0;
                    mf_nxt         = '0;
                end else if (pos == LAST_WORD && mf == 2'd3) begin
                    state_nxt  = ST_DATA;
                    config_nxt = stage_nxt;
                    pos_nxt    = '0;
                    mf_nxt     = '0;
                    prev_nxt   = '0;
                end else if (pos == LAST_WORD) begin
                    pos_nxt = '0;
                    mf_nxt  = mf + 2'd1;
                end else begin
                    pos_nxt = pos + PW'(NUM_OCT);
                end
            end
            ST_DATA: begin
                if (is_k_word) begin
                    state_nxt = ST_CGS;
                    pos_nxt   = '0;
                    k_cnt_nxt = '0;
                end else begin
                    // Lanes are walked in order so a frame ending at a lower lane
                    // feeds its restored octet to a later lane in the same word.
                    for (int i = 0; i < NUM_OCT; i++) begin
                        octet = in[8*i +: 8];
                        legal = (octet == K_F && eof_flag[i]) || (octet == K_A && eom_flag[i]);
                        if (ctrl_in[i]) begin
                            if (!legal) bad_cnt = bad_cnt + 3'd1;
                            else if (!scramble_enable) octet = prev_c;
                        end
                        out_nxt[8*i +: 8] = octet;
                        if (eof_flag[i]) prev_c = octet;
                    end
                    out_valid_nxt = 1'b1;
                    eof_nxt       = eof_flag;
                    eom_nxt       = eom_flag;
                    prev_nxt      = prev_c;
                    ukc_sum       = {1'b0, unexpected_k_count} + 9'(bad_cnt);
                    ukc_nxt       = ukc_sum[8] ? 8'hFF : ukc_sum[7:0];
                    pos_nxt       = (pos == LAST_WORD) ? '0 : pos + PW'(NUM_OCT);
                end
            end
            default: state_nxt = ST_CGS;
        endcase
    end

    // State and registered outputs; SYNC~ and link status follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_CGS;
            k_cnt              <= '0;
            pos                <= '0;
            mf                 <= '0;
            prev               <= '0;
            stage              <= '0;
            config_out         <= '0;
            sync_request       <= 1'b1;
            link_up            <= 1'b0;
            out                <= '0;
            out_valid          <= 1'b0;
            eof_out            <= '0;
            eom_out            <= '0;
            ilas_error         <= 1'b0;
            unexpected_k_count <= '0;
        end else begin
            state              <= state_nxt;
            k_cnt              <= k_cnt_nxt;
            pos                <= pos_nxt;
            mf                 <= mf_nxt;
            prev               <= prev_nxt;
            stage              <= stage_nxt;
            config_out         <= config_nxt;
            sync_request       <= (state_nxt == ST_CGS);
            link_up            <= (state_nxt == ST_DATA);
            out                <= out_nxt;
            out_valid          <= out_valid_nxt;
            eof_out            <= eof_nxt;
            eom_out            <= eom_nxt;
            ilas_error         <= ilas_error_nxt;
            unexpected_k_count <= ukc_nxt;
        end
    end
endmodule

// File: tb/tb_jesd204b_dl_rx.sv
// Directed bench for jesd204b_dl_rx: CGS/ILAS handshake, config capture, /F/ /A/
// restoration, illegal-K counting and re-sync, with a scoreboard on the data output.
module tb_jesd204b_dl_rx;
    localparam int F            = 5;
    localparam int K            = 4;
    localparam int MF_OCT       = F * K;
    localparam int WORDS_PER_MF = MF_OCT / 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  eof;
        logic [3:0]  eom;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         scramble_enable;
    logic [31:0]  lane_in;
    logic [3:0]   ctrl_in;
    logic         sync_request, link_up, out_valid, ilas_error;
    logic [31:0]  lane_out;
    logic [3:0]   eof_out, eom_out;
    logic [111:0] config_out;
    logic [7:0]   unexpected_k_count;

    int           checks = 0;
    int           errors = 0;
    exp_t         sb[$];
    exp_t         sb_head;
    logic [7:0]   mf_oct [MF_OCT];
    logic         mf_k   [MF_OCT];
    logic [7:0]   mf_exp [MF_OCT];
    logic [3:0]   eof_tab [WORDS_PER_MF] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0]   eom_tab [WORDS_PER_MF] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    logic [111:0] cfg_expected;
    exp_t         e;

    always #5 clk = ~clk;

    jesd204b_dl_rx #(.LANE_DATA_WIDTH(32), .OCTETS_PER_FR(F), .FRAMES_PER_MF(K)) dut (
        .clk                (clk),
        .reset              (reset),
        .scramble_enable    (scramble_enable),
        .in                 (lane_in),
        .ctrl_in            (ctrl_in),
        .sync_request       (sync_request),
        .link_up            (link_up),
        .out                (lane_out),
        .out_valid          (out_valid),
        .eof_out            (eof_out),
        .eom_out            (eom_out),
        .config_out         (config_out),
        .ilas_error         (ilas_error),
        .unexpected_k_count (unexpected_k_count)
    );

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: every valid output word must match the oldest pending expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("[TB] FAIL sb_unexpected: observed out=%h expected no output", lane_out);
            end
            if (sb.size() != 0) begin
                sb_head = sb.pop_front();
                check_output("sb_out", lane_out, sb_head.data);
                check_output("sb_eof", eof_out, sb_head.eof);
                check_output("sb_eom", eom_out, sb_head.eom);
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] word, input logic [3:0] ctrl);
        @(negedge clk);
        lane_in = word;
        ctrl_in = ctrl;
        @(posedge clk);
        #1;
    endtask

    task automatic send_k_words(input int n);
        repeat (n) apply_stimulus(32'hBCBCBCBC, 4'hF);
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_sync"}, sync_request, 1'b1);
        check_output({tag, "_link"}, link_up, 1'b0);
        check_output({tag, "_out"}, lane_out, 32'h0);
        check_output({tag, "_valid"}, out_valid, 1'b0);
        check_output({tag, "_eof"}, eof_out, 4'h0);
        check_output({tag, "_eom"}, eom_out, 4'h0);
        check_output({tag, "_config"}, config_out, 112'h0);
        check_output({tag, "_ilas_err"}, ilas_error, 1'b0);
        check_output({tag, "_ukc"}, unexpected_k_count, 8'h0);
    endtask

    // Sends the 4-multiframe ILAS; a fault replaces one octet with 0x00 data and ends it early.
    task automatic send_ilas(input logic [7:0] cfg_base, input int bad_mf, input int bad_p);
        logic [31:0] word;
        logic [3:0]  ctrl;
        logic [7:0]  oct;
        logic        kb;
        int          p;
        bit          faulty;
        for (int m = 0; m < 4; m++) begin
            for (int w = 0; w < WORDS_PER_MF; w++) begin
                faulty = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    p = 4 * w + i;
                    if (p == 0) begin
                        oct = 8'h1C; kb = 1'b1;
                    end else if (p == MF_OCT - 1) begin
                        oct = 8'h7C; kb = 1'b1;
                    end else if (m == 1 && p == 1) begin
                        oct = 8'h9C; kb = 1'b1;
                    end else if (m == 1 && p >= 2 && p <= 15) begin
                        oct = cfg_base + 8'(p - 2); kb = 1'b0;
                    end else begin
                        oct = 8'(64 + 16 * m + p); kb = 1'b0;
                    end
                    if (m == bad_mf && p == bad_p) begin
                        oct = 8'h00; kb = 1'b0; faulty = 1'b1;
                    end
                    word[8*i +: 8] = oct;
                    ctrl[i] = kb;
                end
                apply_stimulus(word, ctrl);
                if (faulty) begin
                    check_output("ilas_error_pulse", ilas_error, 1'b1);
                    check_output("ilas_fail_sync", sync_request, 1'b1);
                    check_output("ilas_fail_link", link_up, 1'b0);
                    return;
                end
                check_output("ilas_no_error", ilas_error, 1'b0);
                check_output("ilas_sync_low", sync_request, 1'b0);
                check_output("ilas_link", link_up, (m == 3 && w == WORDS_PER_MF - 1));
            end
        end
    endtask

    task automatic fill_mf(input logic [7:0] base);
        for (int p = 0; p < MF_OCT; p++) begin
            mf_oct[p] = base + 8'(p);
            mf_k[p]   = 1'b0;
            mf_exp[p] = base + 8'(p);
        end
    endtask

    task automatic set_octet(input int p, input logic [7:0] v, input logic k, input logic [7:0] exp_v);
        mf_oct[p] = v;
        mf_k[p]   = k;
        mf_exp[p] = exp_v;
    endtask

    task automatic send_data_mf();
        logic [31:0] word, exp_word;
        logic [3:0]  ctrl;
        exp_t        x;
        for (int w = 0; w < WORDS_PER_MF; w++) begin
            for (int i = 0; i < 4; i++) begin
                word[8*i +: 8]     = mf_oct[4*w+i];
                ctrl[i]            = mf_k[4*w+i];
                exp_word[8*i +: 8] = mf_exp[4*w+i];
            end
            x.data = exp_word;
            x.eof  = eof_tab[w];
            x.eom  = eom_tab[w];
            sb.push_back(x);
            apply_stimulus(word, ctrl);
            check_output("data_valid", out_valid, 1'b1);
        end
    endtask

    task automatic set_cfg_expected(input logic [7:0] base);
        for (int n = 0; n < 14; n++) cfg_expected[8*n +: 8] = base + 8'(n);
    endtask

    initial begin
        reset = 1'b1;
        scramble_enable = 1'b0;
        lane_in = '0;
        ctrl_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] CGS handshake");
        for (int n = 0; n < 3; n++) begin
            send_k_words(1);
            check_output("cgs_sync_k", sync_request, 1'b1);
        end
        apply_stimulus(32'h11223344, 4'h0);
        check_output("cgs_sync_break", sync_request, 1'b1);
        for (int n = 0; n < 3; n++) begin
            send_k_words(1);
            check_output("cgs_sync_k2", sync_request, 1'b1);
        end
        send_k_words(1);
        check_output("cgs_sync_drop", sync_request, 1'b0);
        check_output("cgs_link", link_up, 1'b0);

        $display("[TB] good ILAS");
        send_ilas(8'h01, -1, -1);
        set_cfg_expected(8'h01);
        check_output("ilas_config", config_out, cfg_expected);
        check_output("ilas_link_up", link_up, 1'b1);
        check_output("ilas_valid_lag", out_valid, 1'b0);

        $display("[TB] /F/ restoration");
        fill_mf(8'h80);
        set_octet(4, 8'h55, 1'b0, 8'h55);
        set_octet(9, 8'hFC, 1'b1, 8'h55);
        set_octet(14, 8'hFC, 1'b1, 8'h55);
        send_data_mf();
        check_output("f_ukc", unexpected_k_count, 8'd0);

        $display("[TB] /A/ restoration and illegal K");
        fill_mf(8'hA0);
        set_octet(2, 8'hFC, 1'b1, 8'hFC);
        set_octet(14, 8'h33, 1'b0, 8'h33);
        set_octet(19, 8'h7C, 1'b1, 8'h33);
        send_data_mf();
        check_output("a_ukc", unexpected_k_count, 8'd1);

        scramble_enable = 1'b1;
        fill_mf(8'hC0);
        set_octet(14, 8'h33, 1'b0, 8'h33);
        set_octet(19, 8'h7C, 1'b1, 8'h7C);
        send_data_mf();
        check_output("scr_ukc", unexpected_k_count, 8'd1);
        scramble_enable = 1'b0;

        $display("[TB] illegal-K count saturation");
        for (int n = 0; n < 65; n++) begin
            e.data = 32'hDC5C3C1C;
            e.eof  = eof_tab[n % WORDS_PER_MF];
            e.eom  = eom_tab[n % WORDS_PER_MF];
            sb.push_back(e);
            apply_stimulus(32'hDC5C3C1C, 4'hF);
            if (n == 62) check_output("ukc_253", unexpected_k_count, 8'd253);
            if (n >= 63) check_output("ukc_sat", unexpected_k_count, 8'd255);
        end

        $display("[TB] re-sync");
        send_k_words(1);
        check_output("resync_link", link_up, 1'b0);
        check_output("resync_valid", out_valid, 1'b0);
        check_output("resync_sync", sync_request, 1'b1);
        send_k_words(3);
        check_output("resync_sync_k3", sync_request, 1'b1);
        send_k_words(1);
        check_output("resync_sync_drop", sync_request, 1'b0);

        $display("[TB] ILAS fault");
        send_ilas(8'h21, 2, 19);
        send_k_words(1);
        check_output("fault_pulse_end", ilas_error, 1'b0);
        check_output("fault_config_kept", config_out, cfg_expected);
        check_output("fault_sync", sync_request, 1'b1);
        send_k_words(3);
        check_output("fault_sync_drop", sync_request, 1'b0);

        send_ilas(8'h41, -1, -1);
        set_cfg_expected(8'h41);
        check_output("reilas_config", config_out, cfg_expected);
        check_output("reilas_link_up", link_up, 1'b1);

        $display("[TB] prev cleared on DATA entry");
        fill_mf(8'h10);
        set_octet(4, 8'hFC, 1'b1, 8'h00);
        send_data_mf();
        check_output("prev_ukc", unexpected_k_count, 8'd255);

        $display("[TB] reset from DATA");
        @(negedge clk);
        reset   = 1'b1;
        lane_in = 32'hBCBCBCBC;
        ctrl_in = 4'hF;
        @(posedge clk);
        #1;
        check_reset_state("rereset");
        repeat (3) @(posedge clk);
        #1;
        check_output("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jesd204b_dl_rx.md
# jesd204b_dl_rx

JESD204B data link layer receiver for one lane, sitting directly downstream of the lane's 8b/10b decoder and feeding the receive transport layer. It drives the SYNC request through code group synchronisation (CGS) and checks the 4-multiframe initial lane alignment sequence (ILAS), capturing the 14 link configuration octets. In user-data mode it restores octets that the transmitter replaced with /F/ (K28.7, 0xFC) and /A/ (K28.3, 0x7C) alignment characters, and it delivers aligned words with frame and multiframe markers. Octet 0 is bits [7:0] and is the earliest octet on the lane.

## Interface
- LANE_DATA_WIDTH, 32: lane word width; fixed at 4 octets.
- OCTETS_PER_FR, 5: F, octets per frame (1..16).
- FRAMES_PER_MF, 4: K, frames per multiframe; F*K must be a multiple of 4, at least 20 and at most 128.
- clk  in  1  lane clock; reset reset, synchronous, active-high; clock clk.
- reset  in  1  synchronous, active-high.
- scramble_enable  in  1  when 1, alignment-character replacement is not reversed.
- in  in  32  decoded lane word.
- ctrl_in  in  4  per-octet K-character flag.
- sync_request  out  1  1 requests CGS from the transmitter (SYNC~ asserted).
- link_up  out  1  1 while in DATA.
- out  out  32  restored user data.
- out_valid  out  1  out carries user data.
- eof_out  out  4  per-octet end-of-frame flags, qualified by out_valid.
- eom_out  out  4  per-octet end-of-multiframe flags, qualified by out_valid.
- config_out  out  112  ILAS configuration octets 0..13; octet n is at [8n+7:8n].
- ilas_error  out  1  one-cycle pulse on an ILAS check failure.
- unexpected_k_count  out  8  saturating count of illegal K octets seen in DATA.

## Operation
- A K-octet is an octet whose ctrl_in bit is 1. A /K/ word has all 4 octets equal to 0xBC with K set.
- State CGS: sync_request=1. Count consecutive /K/ words; any other word clears the count. At a count of 4, go to CGS_WAIT.
- State CGS_WAIT: sync_request=0.
  - A /K/ word: stay.
  - A word with octet 0 = 0x1C K (/R/): go to ILAS. This word is multiframe 0, octet index 0.
  - Any other word: go to CGS.
- State ILAS: the octet index runs 0..F*K-1 in steps of 4, over multiframes 0..3. The following are checked:
  - octet 0 is /R/ 0x1C K;
  - octet F*K-1 is /A/ 0x7C K;
  - in multiframe 1, octet 1 is /Q/ 0x9C K;
  - all other octets are data (K=0).
- Multiframe 1 octets 2..15 are written to config_out octets 0..13.
- Any check failure: pulse ilas_error, go to CGS, and leave config_out unchanged (the capture is staged and committed only when ILAS completes).
- After the last word of multiframe 3: go to DATA. config_out is committed at this point.
- State DATA: link_up=1 and out_valid=1.
  - Frame position is tracked per octet. Octet index p is eof when (p+1) mod F = 0, and eom when p = F*K-1. Markers are carried to eof_out and eom_out.
  - prev holds the restored last octet of the previous frame. It is initialised to 0x00 on DATA entry and is updated at every eof after restoration. If the previous frame ends in the same word at a lower lane, that restored value is used within the same cycle.
- DATA with scramble_enable=0:
  - K 0xFC at an eof octet is replaced by prev.
  - K 0x7C at an eom octet is replaced by prev.
  - Any other K octet is passed through unchanged and increments unexpected_k_count.
- DATA with scramble_enable=1: octets pass through unchanged. K 0xFC at eof and K 0x7C at eom are legal; other K octets are counted.
- A /K/ word in DATA: go to CGS on the next cycle (re-sync). That word is not output; out_valid=0.
- unexpected_k_count adds the number of illegal K octets in the word (0..4) and saturates at 255. It is cleared only by reset.

## Timing
- Reset values: sync_request=1, link_up=0, out=0, out_valid=0, eof_out=0, eom_out=0, config_out=0, ilas_error=0, unexpected_k_count=0, state CGS, all counters 0.
- All outputs are registered. A word sampled at edge n appears on out at edge n+1.
- sync_request falls in the cycle after the 4th consecutive /K/ word is sampled. It rises in the cycle after a CGS_WAIT failure, an ILAS failure, or a DATA /K/ word is sampled.
- ILAS takes exactly 4*F*K/4 words, i.e. F*K words. The first DATA word is the word after the last ILAS word; its out_valid is seen one edge later.
- ilas_error is high for exactly one cycle, aligned with sync_request rising.
- Reset asserted in any state returns every output to its reset value on the next edge.

## Test plan
- CGS handshake: reset, then 3 /K/ words, 1 data word, 4 /K/ words -> sync_request stays 1 through the first 4 words; sync_request=0 one cycle after the 8th word.
- Good ILAS (F=5, K=4, config octets 0x01..0x0E): send /R/ then 4 multiframes -> config_out = 0x0E..01, link_up=1 after the 20th word, ilas_error never pulses.
- ILAS fault: multiframe 2, octet 19 sent as 0x00 data -> ilas_error single pulse, sync_request=1, config_out stays at its prior value.
- /F/ reversal, scramble off: frame 1 octet 4 = 0x55 data, octet 9 = 0xFC K -> out octet 9 = 0x55, eof_out[1]=1, unexpected_k_count=0.
- /A/ reversal and illegal K: octet 14 = 0x33, octet 19 = 0x7C K, and octet 2 = 0xFC K -> octet 19 restored to 0x33, eom_out[3]=1, octet 2 passed through as 0xFC, count=1. Repeat with scramble_enable=1 -> octet 19 output is 0x7C, count unchanged.
- Re-sync: a /K/ word in DATA -> link_up=0, out_valid=0, sync_request=1 on the next edge. Then 4 /K/ words plus a valid ILAS -> link_up=1 again.
